// File: rtl/binary_mul_5_1_uni.sv
// Unsigned 5x5 array multiplier (AND partial products + ripple adder rows) with a registered 10-bit product.
// Optional macro BMUL_INPUT_REG_EN adds enable-gated operand registers (latency 2).
module binary_mul_5_1_uni (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] A,
  input  logic [4:0] B,
  output logic [9:0] P
);

  logic [4:0] a_op;
  logic [4:0] b_op;

`ifdef BMUL_INPUT_REG_EN
  logic [4:0] a_reg;
  logic [4:0] b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= 5'd0;
      b_reg <= 5'd0;
    end else if (en) begin
      a_reg <= A;
      b_reg <= B;
    end
  end

  assign a_op = a_reg;
  assign b_op = b_reg;
`else
  assign a_op = A;
  assign b_op = B;
`endif

  // pp[j][i] = A[i] & B[j]
  logic [4:0] pp [5];
  // Running sum of each row and the carry out of its top bit
  logic [4:0] row_sum [5];
  logic       row_cout [5];

  genvar gi, gj;
  generate
    for (gj = 0; gj < 5; gj++) begin : g_pp
      assign pp[gj] = a_op & {5{b_op[gj]}};
    end

    assign row_sum[0]  = pp[0];
    assign row_cout[0] = 1'b0;

    for (gj = 1; gj < 5; gj++) begin : g_row
      logic [4:0] prev;
      logic [4:0] s;
      logic [4:0] c;

      // Previous row shifted right by one: its LSB already became a product bit
      assign prev = {row_cout[gj-1], row_sum[gj-1][4:1]};

      assign s[0] = pp[gj][0] ^ prev[0];
      assign c[0] = pp[gj][0] & prev[0];

      for (gi = 1; gi < 5; gi++) begin : g_fa
        assign s[gi] = pp[gj][gi] ^ prev[gi] ^ c[gi-1];
        assign c[gi] = (pp[gj][gi] & prev[gi]) | (pp[gj][gi] & c[gi-1]) | (prev[gi] & c[gi-1]);
      end

      assign row_sum[gj]  = s;
      assign row_cout[gj] = c[4];
    end
  endgenerate

  logic [9:0] prod;
  assign prod = {row_cout[4], row_sum[4], row_sum[3][0], row_sum[2][0], row_sum[1][0], row_sum[0][0]};

  logic [9:0] p_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= 10'd0;
    end else if (en) begin
      p_reg <= prod;
    end
  end

  assign P = p_reg;

endmodule

// File: tb/tb_binary_mul_5_1_uni.sv
// Scoreboard bench for binary_mul_5_1_uni: expected products are queued at drive time and popped at output time.
module tb_binary_mul_5_1_uni;

`ifdef BMUL_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] A;
  logic [4:0] B;
  logic [9:0] P;

  int total_cnt;
  int bad_cnt;
  logic [9:0] exp_q [$];

  binary_mul_5_1_uni dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one enabled transaction at the falling edge; compare once the pipeline is full.
  task automatic apply(input int a, input int b);
    logic [9:0] exp;
    @(negedge clk);
    A  = 5'(a);
    B  = 5'(b);
    en = 1'b1;
    exp_q.push_back(10'(a * b));
    @(posedge clk);
    #1;
    if (exp_q.size() >= LAT) begin
      exp = exp_q.pop_front();
      $display("txn %0d*%0d P=%0d exp=%0d", a, b, P, exp);
      check("product", P, exp);
    end
  endtask

  task automatic flush();
    for (int k = 0; k < LAT - 1; k++) apply(0, 0);
    exp_q.delete();
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    A     = 5'd31;
    B     = 5'd31;

    // Reset held with max operands
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", P, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        apply(a, b);
    flush();

    // Enable hold
    apply(5, 6);
    flush();
    @(negedge clk);
    en = 1'b0;
    A  = 5'd31;
    B  = 5'd31;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      $display("txn hold cycle %0d P=%0d exp=30", k, P);
      check("en_hold", P, 10'd30);
    end
    apply(31, 31);
    flush();

    // Zero and identity
    apply(0, 19);
    apply(0, 31);
    apply(1, 23);
    apply(17, 1);
    flush();

    // Back-to-back
    apply(3, 3);
    apply(4, 4);
    apply(30, 2);
    flush();

    // Asynchronous reset mid-cycle
    apply(31, 31);
    flush();
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async reset P=%0d exp=0", P);
    check("async_reset", P, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    apply(7, 9);
    flush();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/binary_mul_5_1_uni.md
# binary_mul_5_1_uni

- Unsigned 5x5-bit multiplier with a single registered output stage: 10-bit product `P = A*B`, one clock after the operands are sampled.
- Built as an explicit partial-product array (AND gates) reduced by ripple full/half-adder rows, not the `*` operator, so the gate structure is visible for synthesis and area comparison.
- Used as a leaf arithmetic unit in the binary multiplier family, under its enable-gated datapath control.

## Interface
- No parameters; widths fixed at 5x5 -> 10.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `en`  input  1  register update enable; active high.
- `A`  input  5  unsigned multiplicand.
- `B`  input  5  unsigned multiplier.
- `P`  output  10  registered unsigned product.

## Operation
- Partial products: `pp[j][i] = A[i] & B[j]` for i, j = 0..4 (25 bits).
- Reduction is an array multiplier:
  - Row 0 is `pp[0]`.
  - Each following row adds `pp[j]`, shifted left by j, to the running sum, using half adders at the row ends and full adders elsewhere.
  - Carries ripple within each row.
  - The final row's carry-out is `P[9]`.
- The combinational result is exact for all 1024 operand pairs. No truncation or saturation; maximum is 31*31 = 961, which fits in 10 bits.
- Output register:
  - `rst_n` low: `P` <= 0 immediately, regardless of `clk`.
  - Rising edge with `en` = 1: `P` <= `A*B`, using the operands present at that edge.
  - Rising edge with `en` = 0: `P` holds its value; operand changes are ignored.
- Operands are treated as unsigned. No sign extension.

## Timing
- Latency is 1 cycle.
  - Operands that are stable before rising edge N appear on `P` just after edge N and stay there until the next enabled edge.
  - Throughput is one product per cycle.
- `A` and `B` must meet setup/hold at the rising edge. The combinational path is the AND array plus 4 ripple adder rows.
- Reset:
  - Asynchronous assertion.
  - Deassertion is sampled at the next rising edge. The first capture is at the first rising edge with `rst_n` = 1 and `en` = 1.
- Reset asserted mid-operation: `P` goes to 0 at once. Any in-flight product is lost.
- `en` and an operand change at the same edge: the register captures the operands present at that edge.

## Configuration
- Macro `BMUL_INPUT_REG_EN`.
- Defined:
  - `A` and `B` are first captured into 5-bit input registers, which reset to 0 asynchronously and are gated by `en`.
  - The product of the registered operands then feeds the output register.
  - Latency becomes 2 enabled cycles. Throughput is unchanged.
- Undefined (default): no input registers; latency is 1 cycle as specified above.

## Test plan
- Reset:
  - Hold `rst_n` = 0 with `A` = 31 and `B` = 31 -> `P` = 0 during reset.
  - Assert `rst_n` = 0 asynchronously mid-cycle -> `P` clears within the same cycle, with no clock edge.
- Exhaustive sweep, `en` = 1:
  - Apply `A` = 0..31, `B` = 0..15 at the falling edge, check 1 time unit after the next rising edge -> `P` = A*B for all 512 pairs (e.g. 7*9 = 63, 31*15 = 465).
  - Extend `B` to 0..31 -> all 1024 pairs exact, including 31*31 = 961 and 16*16 = 256.
- Enable hold: compute 5*6 = 30, then drop `en`, apply `A` = 31, `B` = 31 for 3 cycles -> `P` stays 30. Raise `en` -> `P` = 961 after the next rising edge.
- Zero and identity: `A` = 0 with any B -> 0; `A` = 1, `B` = 23 -> 23; `A` = 17, `B` = 1 -> 17.
- Back-to-back: change operands every cycle (3*3, 4*4, 30*2) -> `P` sequence is 9, 16, 60 on consecutive edges. With `BMUL_INPUT_REG_EN` defined, the same sequence appears one cycle later.
